instr_encoder: RTL

//   Packs symbolic LEGv8 operations (op code + register/immediate fields) into 32-bit

---
 rtl/instr_encoder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - LEGv8 instruction packer with byte-address tagging and output FIFO.
// The instruction is encoded combinationally and lands in the FIFO on the accepting edge.
module instr_encoder #(
    parameter int AW         = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_op,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rn,
    input  logic [4:0]    in_rm,
    input  logic [31:0]   in_imm,
    input  logic          addr_load,
    input  logic [AW-1:0] addr_init,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_word,
    output logic [AW-1:0] out_addr,
    output logic          err,
    input  logic          err_clr
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_ORR  = 5'd3;
    localparam logic [4:0] OP_EOR  = 5'd4,  OP_ADDI = 5'd5,  OP_SUBI = 5'd6,  OP_ANDI = 5'd7;
    localparam logic [4:0] OP_ORRI = 5'd8,  OP_EORI = 5'd9,  OP_LDUR = 5'd10, OP_STUR = 5'd11;
    localparam logic [4:0] OP_MOVZ = 5'd12, OP_CBZ  = 5'd13, OP_B    = 5'd14, OP_BL   = 5'd15;

    // True when imm is representable as an n-bit two's-complement value.
    function automatic logic fits(input logic [31:0] imm, input int n);
        logic [31:0] upper;
        upper = $unsigned($signed(imm) >>> (n - 1));
        return (upper == 32'h0) || (upper == 32'hFFFF_FFFF);
    endfunction

    logic [31:0]   mem_word [FIFO_DEPTH];
    logic [AW-1:0] mem_addr [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [CW-1:0] count, count_next, cnt_after_pop;
    logic [AW-1:0] pc, entry_addr;
    logic [31:0]   enc_word;
    logic          bad, accept, push, pop;

    always_comb begin
        enc_word = 32'h0;
        bad      = 1'b0;
        case (in_op)
            OP_ADD:  enc_word = {11'b10001011000, in_rm, 6'b0, in_rn, in_rd};
            OP_SUB:  enc_word = {11'b11001011000, in_rm, 6'b0, in_rn, in_rd};
            OP_AND:  enc_word = {11'b10001010000, in_rm, 6'b0, in_rn, in_rd};
            OP_ORR:  enc_word = {11'b10101010000, in_rm, 6'b0, in_rn, in_rd};
            OP_EOR:  enc_word = {11'b11101010000, in_rm, 6'b0, in_rn, in_rd};
            OP_ADDI: begin enc_word = {10'b1001000100, in_imm[11:0], in_rn, in_rd}; bad = !fits(in_imm, 12); end
            OP_SUBI: begin enc_word = {10'b1101000100, in_imm[11:0], in_rn, in_rd}; bad = !fits(in_imm, 12); end
            OP_ANDI: begin enc_word = {10'b1001001000, in_imm[11:0], in_rn, in_rd}; bad = !fits(in_imm, 12); end
            OP_ORRI: begin enc_word = {10'b1011001000, in_imm[11:0], in_rn, in_rd}; bad = !fits(in_imm, 12); end
            OP_EORI: begin enc_word = {10'b1101001000, in_imm[11:0], in_rn, in_rd}; bad = !fits(in_imm, 12); end
            OP_LDUR: begin enc_word = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rd}; bad = !fits(in_imm, 9); end
            OP_STUR: begin enc_word = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rd}; bad = !fits(in_imm, 9); end
            OP_MOVZ: begin enc_word = {9'b110100101, in_imm[17:0], in_rd}; bad = !fits(in_imm, 18); end
            OP_CBZ:  begin enc_word = {8'b10110100, in_imm[18:0], in_rd}; bad = !fits(in_imm, 19); end
            OP_B:    begin enc_word = {6'b000101, in_imm[25:0]}; bad = !fits(in_imm, 26); end
            OP_BL:   begin enc_word = {6'b100101, in_imm[25:0]}; bad = !fits(in_imm, 26); end
            default: bad = 1'b1;
        endcase
    end

    assign in_ready   = (count != FULL);
    assign accept     = in_valid && in_ready;
    assign push       = accept && !bad;
    assign pop        = out_valid && out_ready;
    assign entry_addr = addr_load ? addr_init : pc;

    assign cnt_after_pop = count - CW'(pop);
    assign count_next    = cnt_after_pop + CW'(push);
    assign rd_next       = rd_ptr + PW'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_word[wr_ptr] <= enc_word;
            mem_addr[wr_ptr] <= entry_addr;
        end
    end

    // out_word/out_addr are a registered copy of the head so they hold once the FIFO drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_word  <= 32'h0;
            out_addr  <= '0;
            pc        <= '0;
            err       <= 1'b0;
        end else begin
            count     <= count_next;
            rd_ptr    <= rd_next;
            out_valid <= (count_next != '0);
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (push && (cnt_after_pop == '0)) begin
                out_word <= enc_word;
                out_addr <= entry_addr;
            end else if (cnt_after_pop != '0) begin
                out_word <= mem_word[rd_next];
                out_addr <= mem_addr[rd_next];
            end
            if (push) begin
                pc <= entry_addr + AW'(4);
            end else if (addr_load) begin
                pc <= addr_init;
            end
            if (accept && bad) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule
